// File: rtl/up_down_count_monitor.sv
// up_down_count_monitor
// Watches the count bus of an up/down counter, tracks its direction and
// flags illegal jumps, direction reversals and wrap-arounds.
//
// Optional feature: define UP_DOWN_MON_ERR_CNT_EN to add err_cnt, a
// saturating 8-bit count of err pulses.
//
// Timing: q_in is registered into cur_q; the previous cur_q sits in prev_q.
// The pair (cur_q, prev_q) is classified combinationally and every output
// is registered, so a q_in change before edge N shows on the outputs after
// edge N+1. The block has no handshake: it observes the bus every cycle.
// dbg_state_o exposes the FSM state (IDLE=0, ARMED=1, UP=2, DOWN=3).
module up_down_count_monitor #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic [WIDTH-1:0]  q_in,
  output logic              dir,
  output logic              locked,
  output logic              err,
  output logic              rev,
  output logic              wrap,
  output logic [STEP_W-1:0] step_cnt,
`ifdef UP_DOWN_MON_ERR_CNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_UP    = 2'd2,
    S_DOWN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    cur_q, prev_q;
  logic                dir_q, dir_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                rev_q, rev_d;
  logic                wrap_q, wrap_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic [WIDTH-1:0]    prev_inc, prev_dec;
  logic                is_inc, is_dec, is_same, is_bad;

  // Classify the latest sample against the one before it, modulo 2^WIDTH.
  always_comb begin
    prev_inc = prev_q + WIDTH'(1);
    prev_dec = prev_q - WIDTH'(1);
    is_inc   = (cur_q == prev_inc);
    is_dec   = (cur_q == prev_dec);
    is_same  = (cur_q == prev_q);
    is_bad   = !(is_inc || is_dec || is_same);
  end

  // Next-state and output decode; IDLE only captures, it never classifies.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    rev_d   = 1'b0;
    wrap_d  = 1'b0;
    step_d  = step_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_ARMED;
      end
      S_ARMED: begin
        if (is_inc) begin
          state_d = S_UP;
          dir_d   = 1'b0;
        end else if (is_dec) begin
          state_d = S_DOWN;
          dir_d   = 1'b1;
        end else if (is_bad) begin
          err_d   = 1'b1;
        end
      end
      S_UP: begin
        if (is_dec) begin
          state_d = S_DOWN;
          dir_d   = 1'b1;
          rev_d   = 1'b1;
        end else if (is_bad) begin
          state_d = S_ARMED;
          err_d   = 1'b1;
        end
      end
      S_DOWN: begin
        if (is_inc) begin
          state_d = S_UP;
          dir_d   = 1'b0;
          rev_d   = 1'b1;
        end else if (is_bad) begin
          state_d = S_ARMED;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Step counting and wrap detection apply in every classifying state.
    if (state_q != S_IDLE) begin
      if ((is_inc || is_dec) && (step_q != {STEP_W{1'b1}})) begin
        step_d = step_q + STEP_W'(1);
      end
      wrap_d = (is_inc && (prev_q == {WIDTH{1'b1}})) ||
               (is_dec && (prev_q == {WIDTH{1'b0}}));
    end

    locked_d = (state_d == S_UP) || (state_d == S_DOWN);
  end

  // Sample pipeline, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      prev_q   <= '0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      rev_q    <= 1'b0;
      wrap_q   <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= q_in;
      prev_q   <= cur_q;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      rev_q    <= rev_d;
      wrap_q   <= wrap_d;
      step_q   <= step_d;
    end
  end

`ifdef UP_DOWN_MON_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of err pulses, updated in the same edge as err.
  always_ff @(posedge clk) begin
    if (res) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign dir         = dir_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign rev         = rev_q;
  assign wrap        = wrap_q;
  assign step_cnt    = step_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Testbench for up_down_count_monitor: directed scenarios plus random
// stimulus, checked by a scoreboard fed from a sample-level reference model.
// Two instances run in lockstep: default STEP_W=8 and STEP_W=4 for
// saturation. Define UP_DOWN_MON_ERR_CNT_EN to also check err_cnt.
module tb_up_down_count_monitor;

  localparam int W      = 4;
  localparam int SW     = 8;
  localparam int SW_SAT = 4;

  typedef struct packed {
    logic              dir;
    logic              locked;
    logic              err;
    logic              rev;
    logic              wrap;
    logic [SW-1:0]     steps;
    logic [SW_SAT-1:0] steps_sat;
    logic [7:0]        errs;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res = 1'b1;
  logic [W-1:0] q_in = '0;
  always #5 clk = ~clk;

  logic dir_a, locked_a, err_a, rev_a, wrap_a;
  logic [SW-1:0] step_a;
  logic [1:0] dbg_a;
  logic dir_b, locked_b, err_b, rev_b, wrap_b;
  logic [SW_SAT-1:0] step_b;
  logic [1:0] dbg_b;
`ifdef UP_DOWN_MON_ERR_CNT_EN
  logic [7:0] err_cnt_a, err_cnt_b;
`endif

  up_down_count_monitor #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk), .res(res), .q_in(q_in),
    .dir(dir_a), .locked(locked_a), .err(err_a), .rev(rev_a), .wrap(wrap_a),
    .step_cnt(step_a),
`ifdef UP_DOWN_MON_ERR_CNT_EN
    .err_cnt(err_cnt_a),
`endif
    .dbg_state_o(dbg_a)
  );

  up_down_count_monitor #(.WIDTH(W), .STEP_W(SW_SAT)) dut_sat (
    .clk(clk), .res(res), .q_in(q_in),
    .dir(dir_b), .locked(locked_b), .err(err_b), .rev(rev_b), .wrap(wrap_b),
    .step_cnt(step_b),
`ifdef UP_DOWN_MON_ERR_CNT_EN
    .err_cnt(err_cnt_b),
`endif
    .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes described in the behavioural terms of the monitor.
  localparam int M_IDLE = 0, M_ARMED = 1, M_UP = 2, M_DOWN = 3;
  int m_mode = M_IDLE;
  int m_cur = 0, m_prev = 0;
  int m_dir = 0, m_steps = 0, m_errs = 0;

  task automatic model_edge(input int v, input logic r);
    exp_t e;
    int diff;
    int e_err = 0, e_rev = 0, e_wrap = 0;
    if (r) begin
      m_mode = M_IDLE; m_cur = 0; m_prev = 0;
      m_dir = 0; m_steps = 0; m_errs = 0;
    end else begin
      if (m_mode == M_IDLE) begin
        m_mode = M_ARMED;
      end else begin
        diff = (m_cur - m_prev + 16) % 16;
        if (diff == 1 || diff == 15) begin
          m_steps++;
          if (diff == 1 && m_prev == 15) e_wrap = 1;
          if (diff == 15 && m_prev == 0) e_wrap = 1;
        end
        if (diff == 1) begin
          if (m_mode == M_DOWN) e_rev = 1;
          m_mode = M_UP; m_dir = 0;
        end else if (diff == 15) begin
          if (m_mode == M_UP) e_rev = 1;
          m_mode = M_DOWN; m_dir = 1;
        end else if (diff != 0) begin
          e_err = 1;
          m_mode = M_ARMED;
          if (m_errs < 255) m_errs++;
        end
      end
      m_prev = m_cur;
      m_cur  = v;
    end
    e.dir       = (m_dir != 0);
    e.locked    = (m_mode == M_UP || m_mode == M_DOWN);
    e.err       = (e_err != 0);
    e.rev       = (e_rev != 0);
    e.wrap      = (e_wrap != 0);
    e.steps     = SW'((m_steps > 255) ? 255 : m_steps);
    e.steps_sat = SW_SAT'((m_steps > 15) ? 15 : m_steps);
    e.errs      = 8'(m_errs);
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  int last_v = 0;

  task automatic drive(input int v, input logic r);
    q_in = W'(v);
    res  = r;
    last_v = v;
    @(posedge clk);
    model_edge(v, r);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 1'b1);
    drive(0, 1'b0);
  endtask

  task automatic hold(input int cycles);
    for (int i = 0; i < cycles; i++) drive(last_v, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("dir",       32'(dir_a),    32'(e.dir));
        cmp("locked",    32'(locked_a), 32'(e.locked));
        cmp("err",       32'(err_a),    32'(e.err));
        cmp("rev",       32'(rev_a),    32'(e.rev));
        cmp("wrap",      32'(wrap_a),   32'(e.wrap));
        cmp("step_cnt",  32'(step_a),   32'(e.steps));
        cmp("sat_step",  32'(step_b),   32'(e.steps_sat));
        cmp("sat_wrap",  32'(wrap_b),   32'(e.wrap));
`ifdef UP_DOWN_MON_ERR_CNT_EN
        cmp("err_cnt",   32'(err_cnt_a), 32'(e.errs));
`endif
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, nv;
    // Reset then up-count through the wrap.
    do_reset(2);
    for (int i = 0; i <= 17; i++) drive(i % 16, 1'b0);
    hold(2);
    @(negedge clk);
    cmp("ramp_steps", 32'(step_a), 32'd17);
    cmp("ramp_dir", 32'(dir_a), 32'd0);
    cmp("ramp_locked", 32'(locked_a), 32'd1);

    // Reversal: up to 7 then back down to 5.
    for (int v = 2; v <= 7; v++) drive(v, 1'b0);
    drive(6, 1'b0);
    drive(5, 1'b0);
    hold(2);
    @(negedge clk);
    cmp("rev_steps", 32'(step_a), 32'd25);
    cmp("rev_dir", 32'(dir_a), 32'd1);
    cmp("rev_locked", 32'(locked_a), 32'd1);

    // Illegal jump from UP at 3, then relock on 9->10.
    drive(4, 1'b0); drive(3, 1'b0); drive(2, 1'b0); drive(3, 1'b0);
    drive(9, 1'b0); drive(10, 1'b0);
    hold(2);
    @(negedge clk);
    cmp("jump_relock", 32'(locked_a), 32'd1);
    cmp("jump_dir", 32'(dir_a), 32'd0);

    // UP at 0 then 15: reversal and wrap together.
    for (int v = 11; v <= 16; v++) drive(v % 16, 1'b0);
    drive(15, 1'b0);
    hold(2);
    @(negedge clk);
    cmp("dwrap_dir", 32'(dir_a), 32'd1);

    // Saturation of the narrow counter, then reset mid-sequence.
    do_reset(1);
    for (int i = 1; i <= 21; i++) drive(i % 16, 1'b0);
    hold(2);
    @(negedge clk);
    cmp("sat_hold", 32'(step_b), 32'd15);
    cmp("wide_steps", 32'(step_a), 32'd21);
    drive(7, 1'b0);
    drive(8, 1'b1);
    @(negedge clk);
    cmp("rst_locked", 32'(locked_a), 32'd0);
    cmp("rst_dir", 32'(dir_a), 32'd0);
    cmp("rst_steps", 32'(step_a), 32'd0);
    cmp("rst_pulses", 32'({err_a, rev_a, wrap_a}), 32'd0);
    drive(0, 1'b0);

    // Three illegal jumps while ARMED.
    hold(2);
    drive(5, 1'b0); drive(11, 1'b0); drive(2, 1'b0);
    hold(2);
`ifdef UP_DOWN_MON_ERR_CNT_EN
    @(negedge clk);
    cmp("err_cnt3", 32'(err_cnt_a), 32'd3);
    do_reset(1);
    @(negedge clk);
    cmp("err_cnt_rst", 32'(err_cnt_a), 32'd0);
`endif

    // Random walk with jumps and occasional resets.
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(1, 2));
      end else begin
        if (r < 45)      nv = (last_v + 1) % 16;
        else if (r < 80) nv = (last_v + 15) % 16;
        else if (r < 90) nv = last_v;
        else             nv = $urandom_range(0, 15);
        drive(nv, 1'b0);
      end
    end
    hold(2);
    @(negedge clk);
    @(negedge clk);
    cmp("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
